// File: rtl/aqp_esp_uart_pkg.sv
// Shared definitions for the ESP32 UART link: transmit FSM states and
// frame/FIFO constants used by the transmitter and its FIFO.
package aqp_esp_uart_pkg;

  // Transmit FSM states; the encoding is fixed so the state can be probed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // FIFO occupancy at or above which almost_full is raised.
  localparam int unsigned ALMOST_FULL_THRESH = 32'd8;

  // 8N1 frame: one start bit, eight data bits, one stop bit.
  localparam int unsigned FRAME_BITS = 32'd10;
  localparam int unsigned DATA_BITS  = FRAME_BITS - 32'd2;

endpackage

// File: rtl/aqp_esp_uart_tx_if.sv
// CPU-side write port of the ESP UART transmitter: byte push plus
// FIFO/activity status back to the register logic.
interface aqp_esp_uart_tx_if;

  logic [7:0] wrdata;
  logic       wr_en;
  logic       full;
  logic       almost_full;
  logic       empty;
  logic       busy;

  // Register logic side: pushes bytes, watches status.
  modport master (
    output wrdata,
    output wr_en,
    input  full,
    input  almost_full,
    input  empty,
    input  busy
  );

  // Transmitter side: accepts bytes, reports status.
  modport slave (
    input  wrdata,
    input  wr_en,
    output full,
    output almost_full,
    output empty,
    output busy
  );

endinterface

// File: rtl/aqp_esp_uart_txfifo.sv
// Byte FIFO for the UART transmitter. Wrapping indices, one slot kept
// free so full/empty are distinguishable; head byte is presented
// combinationally (first-word-fall-through). Flags come straight from
// the registered indices.
module aqp_esp_uart_txfifo
  import aqp_esp_uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       almost_full
);

  localparam int unsigned SLOTS = 32'd1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE  = (DEPTH_LOG2)'(32'd1);
  localparam logic [DEPTH_LOG2:0]   AF_LEVEL = (DEPTH_LOG2 + 1)'(ALMOST_FULL_THRESH);

  logic [7:0]            mem_r [SLOTS];
  logic [DEPTH_LOG2-1:0] wr_idx_r;
  logic [DEPTH_LOG2-1:0] rd_idx_r;
  logic [DEPTH_LOG2-1:0] count_s;
  logic                  push_s;
  logic                  pop_s;

  // A push while full is dropped regardless of a simultaneous pop.
  assign push_s      = wr_en && !full;
  assign pop_s       = rd_en && !empty;
  assign count_s     = wr_idx_r - rd_idx_r;
  assign empty       = (wr_idx_r == rd_idx_r);
  assign full        = ((wr_idx_r + IDX_ONE) == rd_idx_r);
  assign almost_full = ({1'b0, count_s} >= AF_LEVEL);
  assign rd_data     = mem_r[rd_idx_r];

  // Advance write/read indices on accepted push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx_r <= {DEPTH_LOG2{1'b0}};
      rd_idx_r <= {DEPTH_LOG2{1'b0}};
    end else begin
      if (push_s) begin
        wr_idx_r <= wr_idx_r + IDX_ONE;
      end
      if (pop_s) begin
        rd_idx_r <= rd_idx_r + IDX_ONE;
      end
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_idx_r] <= wr_data;
    end
  end

endmodule

// File: rtl/aqp_esp_uart_tx.sv
// Transmit half of the host-to-ESP32 UART link. Bytes pushed by the
// register logic are queued in a small FIFO and sent as 8N1 frames,
// LSB first, with a new frame only started while the ESP asserts CTS.
// BAUD_DIV (clocks per bit) must be at least 2.
module aqp_esp_uart_tx
  import aqp_esp_uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = 16,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic               clk,
  input  logic               rst,
  aqp_esp_uart_tx_if.slave   bus,
  input  logic               cts_n,
  output logic               uart_txd
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_LOAD = (CNT_W)'(BAUD_DIV - 32'd1);
  localparam logic [CNT_W-1:0] BAUD_ONE  = (CNT_W)'(32'd1);
  localparam logic [CNT_W-1:0] BAUD_ZERO = {CNT_W{1'b0}};
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 32'd1);

  tx_state_e        state_r, state_d;
  logic [CNT_W-1:0] baud_r, baud_d;
  logic [2:0]       bit_r, bit_d;
  logic [7:0]       shift_r, shift_d;
  logic             txd_r, txd_d;
  logic             cts_meta_r, cts_sync_r;
  logic             cts_ok_s;
  logic             pop_s;
  logic [7:0]       head_s;
  logic             fifo_empty_s;
  logic             fifo_full_s;
  logic             fifo_af_s;

  aqp_esp_uart_txfifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_txfifo (
    .clk         (clk),
    .rst         (rst),
    .wr_data     (bus.wrdata),
    .wr_en       (bus.wr_en),
    .rd_en       (pop_s),
    .rd_data     (head_s),
    .empty       (fifo_empty_s),
    .full        (fifo_full_s),
    .almost_full (fifo_af_s)
  );

  assign cts_ok_s        = !cts_sync_r;
  assign uart_txd        = txd_r;
  assign bus.empty       = fifo_empty_s;
  assign bus.full        = fifo_full_s;
  assign bus.almost_full = fifo_af_s;
  assign bus.busy        = (state_r != ST_IDLE) || !fifo_empty_s;

  // Two-flop synchroniser for cts_n; preset so the link starts "not clear".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cts_meta_r <= 1'b1;
      cts_sync_r <= 1'b1;
    end else begin
      cts_meta_r <= cts_n;
      cts_sync_r <= cts_meta_r;
    end
  end

  // FSM state, baud/bit counters, shifter and the registered pin level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      baud_r  <= BAUD_ZERO;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      txd_r   <= 1'b1;
    end else begin
      state_r <= state_d;
      baud_r  <= baud_d;
      bit_r   <= bit_d;
      shift_r <= shift_d;
      txd_r   <= txd_d;
    end
  end

  // Next-state/datapath logic; CTS is only consulted when a frame starts.
  always_comb begin
    state_d = state_r;
    baud_d  = baud_r;
    bit_d   = bit_r;
    shift_d = shift_r;
    pop_s   = 1'b0;
    txd_d   = 1'b1;

    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s && cts_ok_s) begin
          pop_s   = 1'b1;
          shift_d = head_s;
          baud_d  = BAUD_LOAD;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        if (baud_r == BAUD_ZERO) begin
          baud_d  = BAUD_LOAD;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          baud_d  = baud_r - BAUD_ONE;
        end
      end

      ST_DATA: begin
        if (baud_r == BAUD_ZERO) begin
          shift_d = {1'b0, shift_r[7:1]};
          bit_d   = bit_r + 3'd1;
          baud_d  = BAUD_LOAD;
          if (bit_r == LAST_BIT) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          baud_d  = baud_r - BAUD_ONE;
        end
      end

      ST_STOP: begin
        if (baud_r == BAUD_ZERO) begin
          // Chain straight into the next start bit when possible.
          if (!fifo_empty_s && cts_ok_s) begin
            pop_s   = 1'b1;
            shift_d = head_s;
            baud_d  = BAUD_LOAD;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d  = baud_r - BAUD_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        baud_d  = BAUD_ZERO;
        bit_d   = 3'd0;
      end
    endcase

    // Pin level is taken from the next state so it changes on the same
    // edge as the state and leaves the chip from a flop.
    case (state_d)
      ST_IDLE:  txd_d = 1'b1;
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      ST_STOP:  txd_d = 1'b1;
      default:  txd_d = 1'b1;
    endcase
  end

endmodule

// File: doc/aqp_esp_uart_tx.md
Name: aqp_esp_uart_tx

Overview:
Transmit half of the host-to-ESP32 UART link. Buffers bytes written by the CPU-side register logic in a small FIFO. Serialises each byte as 8N1 on uart_txd at a fixed baud divider, gated by the ESP's hardware flow-control line. Sits beside the existing ESP UART receive path and drives the board's TXD pin directly.

Parameters:
BAUD_DIV, 16, clock cycles per bit period; must be at least 2.
DEPTH_LOG2, 4, log2 of FIFO slots; usable capacity is 2**DEPTH_LOG2 - 1 (15 at default).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
wrdata  input  8  byte to transmit
wr_en  input  1  push wrdata into FIFO this cycle
full  output  1  FIFO holds 15 entries; a push is dropped
almost_full  output  1  FIFO count >= 8
empty  output  1  FIFO holds 0 entries
busy  output  1  frame in progress or FIFO not empty
cts_n  input  1  ESP clear-to-send, active-low, asynchronous to clk
uart_txd  output  1  serial output, idle high

Behaviour:
- Reset is asynchronous and active-high. While rst is high:
  - uart_txd = 1, empty = 1, full = 0, almost_full = 0, busy = 0.
  - FIFO indices cleared; FSM in IDLE; baud counter, bit counter and shifter cleared.
  - cts_n synchroniser flops preset to 1 (not clear).
- Reset mid-frame aborts the frame: uart_txd goes high immediately and all queued bytes are discarded.
- FIFO behaviour:
  - Wrapping 4-bit write and read indices; count = wridx - rdidx, modulo 16.
  - empty = (wridx == rdidx); full = (wridx + 1 == rdidx); almost_full = (count >= 8).
  - Read is first-word-fall-through: the head byte is combinationally visible to the FSM.
  - Flags are registered-index derived. A push when full is dropped, even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle are both honoured when not full and not empty.
- cts_n passes through a 2-flop synchroniser; cts_ok = !cts_n_sync.
- FSM states are IDLE, START, DATA, STOP.
- IDLE:
  - uart_txd = 1.
  - If !empty && cts_ok: pop the head into the shifter, load baud counter = BAUD_DIV-1, go to START.
- START: uart_txd = 0 for BAUD_DIV cycles. When the baud counter reaches 0: reload it, set bit counter = 0, go to DATA.
- DATA:
  - uart_txd = shifter[0], sent LSB first.
  - Each time the baud counter reaches 0: shift right, increment the bit counter, reload.
  - After bit 7 completes, go to STOP.
- STOP: uart_txd = 1 for BAUD_DIV cycles. When the baud counter reaches 0:
  - if !empty && cts_ok: pop and go directly to START, giving no idle gap between frames;
  - else go to IDLE.
- uart_txd is driven from a register; no combinational path to the pin.
- Latency:
  - wr_en sampled at edge E0 into an empty FIFO with cts_ok.
  - IDLE pops at E1; uart_txd falls after E1.
  - The frame occupies exactly 10*BAUD_DIV cycles.
- Flow control:
  - cts_ok is checked only at frame start.
  - Deasserting cts_n mid-frame never truncates the current frame; the next frame waits in IDLE/STOP-exit until cts_ok.
- busy = (state != IDLE) || !empty.

Decomposition:
- The shared aqp_esp_uart package holds:
  - the FSM state enum (IDLE/START/DATA/STOP, 2 bits);
  - the almost-full threshold constant (8);
  - the frame-length constant (10 bit periods).
- One sub-module, aqp_esp_uart_txfifo: 16x8 FIFO with first-word-fall-through read, async reset, and the empty/full/almost_full flags. The top module holds the synchroniser, baud/bit counters, shifter and FSM.

Test Plan:
1. BAUD_DIV=4, cts_n=0, write 0xA5 once -> uart_txd low 1 clk after the pop edge, then 4-clk periods of 0 | 1,0,1,0,0,1,0,1 | 1; busy drops after 40 clks; empty=1.
2. Write 0x01, 0x80, 0xFF back-to-back -> three contiguous 40-clk frames with no idle cycle between the STOP of one frame and the START of the next; byte order preserved.
3. cts_n=1, write 16 bytes -> first 15 accepted; full=1 after the 15th; almost_full=1 from the 8th; the 16th is dropped; uart_txd stays 1. Release cts_n -> exactly 15 frames, in order.
4. Assert cts_n=1 during DATA of frame 1 with a second byte queued -> frame 1 completes intact; uart_txd holds 1 until cts_n=0. The second frame starts 3 clks after release (2 synchroniser cycles plus the pop edge).
5. With full=1, pulse wr_en on the same edge the FSM pops -> the write is dropped; count goes 15->14.
6. Assert rst asynchronously mid-DATA with 5 bytes queued -> uart_txd=1 and empty=1 without waiting for a clock edge. After release, no further frames are sent until new writes.
